// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared state type and stream-format constants for the instruction loader
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    INIT,
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_BYTES = 1;

  // Total stream length in bytes for an image of n_words words.
  function automatic int image_bytes(input int n_words);
    return HDR_BYTES + n_words * WORD_BYTES + CSUM_BYTES;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte-stream input and instruction-memory write port of the loader
interface instr_mem_loader_if #(
  parameter int ADDR_W = 8
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_wren;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wrdata;

  // master: byte source and memory side; slave: the loader itself
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_wren, imem_addr, imem_wrdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_wren, imem_addr, imem_wrdata
  );

endinterface

// File: rtl/instr_mem_loader_word_pack.sv
// rtl/instr_mem_loader_word_pack.sv - packs MSB-first bytes into 32-bit words
module loader_word_pack
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_data,
  output logic        word_done
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clr) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (shift_en) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[15:0], byte_in};
    end
  end

  // The completed word includes the byte arriving this cycle, so only three are held.
  assign word_done = shift_en && (idx_q == 2'(WORD_BYTES - 1));
  assign word_data = {shift_q, byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot loader writing a checksummed byte image into instruction memory
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  instr_mem_loader_if.slave  bus,
  output logic               cpu_rst_n,
  output logic               load_done,
  output logic               load_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  loader_state_t     state_q, state_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [7:0]        csum_q, csum_d;
  logic              rx_ready_q, rx_ready_d;
  logic              imem_wren_q, imem_wren_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wrdata_q, imem_wrdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              byte_ok;
  logic [15:0]       hdr_n;
  logic [ADDR_W:0]   wcnt_inc;
  logic [31:0]       word_data;
  logic              word_done;

  // A byte coinciding with load_start is dropped entirely.
  assign byte_ok  = bus.rx_valid && rx_ready_q && !load_start;
  assign hdr_n    = {hdr_hi_q, bus.rx_data};
  assign wcnt_inc = wcnt_q + (ADDR_W + 1)'(1);

  loader_word_pack u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (load_start),
    .shift_en  (byte_ok && (state_q == DATA)),
    .byte_in   (bus.rx_data),
    .word_data (word_data),
    .word_done (word_done)
  );

  always_comb begin
    state_d       = state_q;
    hdr_hi_d      = hdr_hi_q;
    count_d       = count_q;
    wcnt_d        = wcnt_q;
    csum_d        = csum_q;
    imem_wren_d   = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wrdata_d = imem_wrdata_q;

    if (byte_ok && (state_q inside {HDR_HI, HDR_LO, DATA})) begin
      csum_d = csum_q ^ bus.rx_data;
    end

    unique case (state_q)
      INIT: state_d = HDR_HI;
      HDR_HI: begin
        if (byte_ok) begin
          hdr_hi_d = bus.rx_data;
          state_d  = HDR_LO;
        end
      end
      HDR_LO: begin
        if (byte_ok) begin
          count_d = (ADDR_W + 1)'(hdr_n);
          if (32'(hdr_n) > DEPTH) begin
            state_d = ERR;
          end else if (hdr_n == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_done) begin
          imem_wren_d   = 1'b1;
          imem_addr_d   = wcnt_q[ADDR_W-1:0];
          imem_wrdata_d = word_data;
          wcnt_d        = wcnt_inc;
          if (wcnt_inc == count_q) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (byte_ok) begin
          state_d = (bus.rx_data == csum_q) ? DONE : ERR;
        end
      end
      DONE, ERR: state_d = state_q;
      default:   state_d = INIT;
    endcase

    if (load_start) begin
      state_d = HDR_HI;
      wcnt_d  = '0;
      csum_d  = '0;
    end

    // Status outputs are registered copies of the next state.
    rx_ready_d  = state_d inside {HDR_HI, HDR_LO, DATA, CSUM};
    cpu_rst_n_d = (state_d == DONE);
    load_done_d = (state_d == DONE);
    load_err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      hdr_hi_q      <= '0;
      count_q       <= '0;
      wcnt_q        <= '0;
      csum_q        <= '0;
      rx_ready_q    <= 1'b0;
      imem_wren_q   <= 1'b0;
      imem_addr_q   <= '0;
      imem_wrdata_q <= '0;
      cpu_rst_n_q   <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_hi_q      <= hdr_hi_d;
      count_q       <= count_d;
      wcnt_q        <= wcnt_d;
      csum_q        <= csum_d;
      rx_ready_q    <= rx_ready_d;
      imem_wren_q   <= imem_wren_d;
      imem_addr_q   <= imem_addr_d;
      imem_wrdata_q <= imem_wrdata_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      load_done_q   <= load_done_d;
      load_err_q    <= load_err_d;
    end
  end

  assign bus.rx_ready    = rx_ready_q;
  assign bus.imem_wren   = imem_wren_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.imem_wrdata = imem_wrdata_q;
  assign cpu_rst_n       = cpu_rst_n_q;
  assign load_done       = load_done_q;
  assign load_err        = load_err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized self-checking bench for instr_mem_loader
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0;
  logic cpu_rst_n, load_done, load_err;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .bus        (bus),
    .cpu_rst_n  (cpu_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]        img[$];
  logic [ADDR_W+31:0] exp_w[$];
  logic [ADDR_W+31:0] got_w[$];
  int                exp_acc;
  bit                exp_ok;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.imem_wren === 1'b1) got_w.push_back({bus.imem_addr, bus.imem_wrdata});
  end

  task automatic append_csum(input bit good);
    logic [7:0] x = 8'h00;
    foreach (img[i]) x ^= img[i];
    img.push_back(good ? x : (x ^ 8'h01));
  endtask

  task automatic make_image(input int n, input bit good);
    int nb;
    img.delete();
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    nb = (n <= DEPTH) ? n * 4 : 4;
    for (int i = 0; i < nb; i++) img.push_back(8'($urandom));
    append_csum(good);
  endtask

  // Reference: parse the stream by its format rules.
  task automatic model();
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    n = int'({img[0], img[1]});
    exp_w.delete();
    if (n > DEPTH) begin
      exp_acc = 2;
      exp_ok  = 1'b0;
      return;
    end
    x = img[0] ^ img[1];
    for (int i = 0; i < n; i++) begin
      w = {img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]};
      x ^= img[2+4*i] ^ img[3+4*i] ^ img[4+4*i] ^ img[5+4*i];
      exp_w.push_back({ADDR_W'(i), w});
    end
    exp_acc = image_bytes(n);
    exp_ok  = (img[exp_acc-1] == x);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_stream(input int n_send, input int gap_pct, input int abort_at);
    int i = 0;
    int idle = 0;
    bit v, r;
    while (i < n_send) begin
      v = ($urandom_range(99) >= gap_pct);
      bus.rx_valid = v;
      bus.rx_data  = v ? img[i] : 8'($urandom);
      load_start   = v && (i == abort_at);
      r = bus.rx_ready;
      @(posedge clk); #1;
      load_start = 1'b0;
      if (v && i == abort_at) begin
        bus.rx_valid = 1'b0;
        return;
      end
      if (v && r) begin
        i++;
        idle = 0;
      end else if (++idle > 100) begin
        check_eq("stall_timeout", i, n_send);
        bus.rx_valid = 1'b0;
        return;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check_eq("start_cpu_rst_n", cpu_rst_n, 0);
    check_eq("start_flags", {load_done, load_err}, 0);
    check_eq("start_rx_ready", bus.rx_ready, 1);
  endtask

  task automatic check_image();
    int nw;
    check_eq("write_count", got_w.size(), exp_w.size());
    nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < nw; i++) check_eq("write_addr_data", got_w[i], exp_w[i]);
    check_eq("load_done", load_done, exp_ok);
    check_eq("load_err", load_err, !exp_ok);
    check_eq("cpu_rst_n", cpu_rst_n, exp_ok);
    check_eq("rx_ready_final", bus.rx_ready, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    check_eq("no_extra_writes", got_w.size(), exp_w.size());
    check_eq("final_state_held", {load_done, load_err, bus.rx_ready}, {exp_ok, !exp_ok, 1'b0});
  endtask

  task automatic run_image(input bit do_start, input int gap_pct);
    if (do_start) pulse_start();
    model();
    got_w.delete();
    send_stream(exp_acc, gap_pct, -1);
    check_image();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {bus.rx_ready, bus.imem_wren, bus.imem_addr, bus.imem_wrdata,
                               cpu_rst_n, load_done, load_err}, 0);
    rst_n = 1'b1;
    check_eq("init_rx_ready", bus.rx_ready, 0);
    @(posedge clk); #1;
    check_eq("first_edge_rx_ready", bus.rx_ready, 1);

    img = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    append_csum(1'b1);
    run_image(1'b0, 0);

    img = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    append_csum(1'b0);
    run_image(1'b1, 0);

    make_image(257, 1'b1);
    run_image(1'b1, 0);

    make_image(0, 1'b1);
    run_image(1'b1, 0);

    make_image(DEPTH, 1'b1);
    run_image(1'b1, 20);

    for (int k = 0; k < 6; k++) begin
      make_image($urandom_range(1, 12), $urandom_range(0, 3) != 0);
      run_image(1'b1, $urandom_range(0, 60));
    end

    // load_start together with the 2nd byte of word 1
    pulse_start();
    make_image(4, 1'b1);
    send_stream(image_bytes(4), 0, 7);
    check_eq("abort_cpu_rst_n", cpu_rst_n, 0);
    check_eq("abort_flags", {load_done, load_err}, 0);
    check_eq("abort_rx_ready", bus.rx_ready, 1);
    make_image(3, 1'b1);
    run_image(1'b0, 25);

    // asynchronous reset while the first write strobe is high
    pulse_start();
    make_image(3, 1'b1);
    model();
    got_w.delete();
    send_stream(6, 0, -1);
    check_eq("write_latency", bus.imem_wren, 1);
    check_eq("write0_addr_data", {bus.imem_addr, bus.imem_wrdata}, exp_w[0]);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs", {bus.rx_ready, bus.imem_wren, bus.imem_addr, bus.imem_wrdata,
                                     cpu_rst_n, load_done, load_err}, 0);
    check_eq("async_reset_no_write", got_w.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_reset_rx_ready", bus.rx_ready, 1);
    make_image(5, 1'b1);
    run_image(1'b0, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
